mem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port 0 = cpu

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/response and memory-side bus of the two-port memory arbiter.
//   slave  : arbiter view (takes requests and mem_rdata, drives ready/rsp/mem_*)
//   master : requester + memory view (the opposite directions)
//   req_valid/req_ready/req_we [1:0]  per-port handshake, bit k = port k
//   req_addr [2*A], req_wdata/req_mask [2*N]  port k payload in slice k
//   rsp_valid [1:0], rsp_data [N]      read return, one-cycle pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_mask/mem_rdata  single-port memory
interface mem_arbiter_if #(
    parameter int unsigned N = 32,
    parameter int unsigned A = 12
);
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [1:0]     req_we;
    logic [2*A-1:0] req_addr;
    logic [2*N-1:0] req_wdata;
    logic [2*N-1:0] req_mask;
    logic [1:0]     rsp_valid;
    logic [N-1:0]   rsp_data;
    logic           mem_en;
    logic           mem_we;
    logic [A-1:0]   mem_addr;
    logic [N-1:0]   mem_wdata;
    logic [N-1:0]   mem_mask;
    logic [N-1:0]   mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_mask, mem_rdata,
        output req_ready, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_wdata, mem_mask
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_mask, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_wdata, mem_mask
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port data memory between port 0 (cpu load/store) and
// port 1 (debug/DMA loader). One access at a time through IDLE -> ISSUE -> (WAIT -> RESP)
// with a valid/ready request handshake and a per-port rsp_valid pulse for read data.
// Ports:
//   i_clk  clock, all state on posedge
//   i_rst  synchronous active-high reset
//   bus    mem_arbiter_if.slave (request, response and memory signals)
// Parameters: N data width, A byte address width, LAT memory read latency (>= 1).
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins);
// default is round-robin.
module mem_arbiter #(
    parameter int unsigned N   = 32,
    parameter int unsigned A   = 12,
    parameter int unsigned LAT = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    logic [1:0]   r_state;
    logic         r_grant;
    logic [CW-1:0] r_cnt;
    logic         r_mem_en;
    logic         r_mem_we;
    logic [A-1:0] r_mem_addr;
    logic [N-1:0] r_mem_wdata;
    logic [N-1:0] r_mem_mask;
    logic [1:0]   r_rsp_valid;
    logic [N-1:0] r_rsp_data;

    logic         w_any;
    logic         w_grant;
    logic         w_sel_we;
    logic [A-1:0] w_sel_addr;
    logic [N-1:0] w_sel_wdata;
    logic [N-1:0] w_sel_mask;

    assign w_any = |bus.req_valid;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Port 0 wins whenever it asks.
    assign w_grant = ~bus.req_valid[0];
`else
    logic r_last_grant;

    // Contested: alternate away from the last winner. Uncontested: the only requester.
    assign w_grant = (&bus.req_valid) ? ~r_last_grant : bus.req_valid[1];

    // Reset to 1 so the first contested grant goes to port 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
        end else if (r_state == ST_IDLE && w_any) begin
            r_last_grant <= w_grant;
        end
    end
`endif

    assign w_sel_we    = w_grant ? bus.req_we[1]        : bus.req_we[0];
    assign w_sel_addr  = w_grant ? bus.req_addr[A +: A] : bus.req_addr[0 +: A];
    assign w_sel_wdata = w_grant ? bus.req_wdata[N +: N] : bus.req_wdata[0 +: N];
    assign w_sel_mask  = w_grant ? bus.req_mask[N +: N]  : bus.req_mask[0 +: N];

    // Accept is combinational in IDLE so the requester sees ready in the grant cycle.
    assign bus.req_ready = (r_state == ST_IDLE && w_any) ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_mask  = r_mem_mask;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= 1'b0;
            r_cnt       <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_mask  <= '0;
            r_rsp_valid <= 2'b00;
            r_rsp_data  <= '0;
        end else begin
            // Strobes are single-cycle; payload registers hold between accesses.
            r_mem_en    <= 1'b0;
            r_rsp_valid <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        // Latch straight into the memory-side registers; they only
                        // change here, so mem_* hold while mem_en is low.
                        r_grant     <= w_grant;
                        r_mem_we    <= w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_mem_mask  <= w_sel_mask;
                        r_mem_en    <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_mem_we) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= CW'(LAT - 1);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_data  <= bus.mem_rdata;
                        r_rsp_valid <= r_grant ? 2'b10 : 2'b01;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven transactions with a response scoreboard against a LAT=1
// arbiter, plus hand-written sequences for contention, reset in WAIT and a LAT=3 instance.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.N(32), .A(12)) bus1 ();
    mem_arbiter_if #(.N(32), .A(12)) bus3 ();

    mem_arbiter #(.N(32), .A(12), .LAT(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
    mem_arbiter #(.N(32), .A(12), .LAT(3)) u_dut3 (.i_clk(clk), .i_rst(rst), .bus(bus3));

    // Memory models: masked write, read data LAT cycles after mem_en; preloaded on reset.
    logic [31:0] mem1 [1024];
    logic [31:0] mem3 [1024];
    logic [31:0] pipe1;
    logic [31:0] pipe3 [3];
    assign bus1.mem_rdata = pipe1;
    assign bus3.mem_rdata = pipe3[2];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem1[i] <= 32'h0;
            mem1[16]  <= 32'hA0A0A0A0;
            mem1[17]  <= 32'hB1B1B1B1;
            mem1[255] <= 32'h5A5A5A5A;
            pipe1     <= 32'h0;
        end else if (bus1.mem_en) begin
            if (bus1.mem_we)
                mem1[bus1.mem_addr[11:2]] <= (mem1[bus1.mem_addr[11:2]] & ~bus1.mem_mask)
                                           | (bus1.mem_wdata & bus1.mem_mask);
            else
                pipe1 <= mem1[bus1.mem_addr[11:2]];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem3[i] <= 32'h0;
            mem3[16] <= 32'hC3C3C3C3;
            for (int i = 0; i < 3; i++) pipe3[i] <= 32'h0;
        end else begin
            if (bus3.mem_en && !bus3.mem_we) pipe3[0] <= mem3[bus3.mem_addr[11:2]];
            pipe3[1] <= pipe3[0];
            pipe3[2] <= pipe3[1];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_men    = 0;
    int n_exp_men = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] oh(input bit p);
        return p ? 2'b10 : 2'b01;
    endfunction

    typedef struct {
        bit          port;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    // Scoreboard: every rsp pulse must match the oldest expected read.
    always @(negedge clk) begin
        if (bus1.mem_en) n_men++;
        if (bus1.rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", {62'h0, bus1.rsp_valid}, 64'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_port", {62'h0, bus1.rsp_valid}, {62'h0, oh(e.port)});
                chk("rsp_data", {32'h0, bus1.rsp_data}, {32'h0, e.data});
                chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    typedef struct {
        bit          port;
        bit          we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] mask;
        logic [31:0] exp;
    } vec_t;

    task automatic idle_inputs();
        bus1.req_valid = 2'b00;
        bus1.req_we    = 2'b00;
        bus1.req_addr  = '0;
        bus1.req_wdata = '0;
        bus1.req_mask  = '0;
    endtask

    // Starts and ends just after a posedge.
    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 20) chk("drain_timeout", 64'(sb.size()), 64'h0);
    endtask

    task automatic do_txn(input vec_t v, input bit imm);
        int waited = 0;
        int t;
        bus1.req_valid = oh(v.port);
        bus1.req_we    = v.we ? oh(v.port) : 2'b00;
        bus1.req_addr  = v.port ? {v.addr, 12'h000} : {12'h000, v.addr};
        bus1.req_wdata = v.port ? {v.wdata, 32'h0} : {32'h0, v.wdata};
        bus1.req_mask  = v.port ? {v.mask, 32'h0} : {32'h0, v.mask};
        forever begin
            @(negedge clk);
            if (bus1.req_ready != 2'b00 || waited >= 20) break;
            waited++;
            @(posedge clk); #1;
        end
        chk("req_ready", {62'h0, bus1.req_ready}, {62'h0, oh(v.port)});
        if (imm) chk("accept_wait", 64'(waited), 64'h0);
        t = cyc;
        if (!v.we) sb.push_back('{port: v.port, data: v.exp, cyc: t + 3});
        n_exp_men++;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("mem_en",    {63'h0, bus1.mem_en}, 64'h1);
        chk("mem_we",    {63'h0, bus1.mem_we}, {63'h0, v.we});
        chk("mem_addr",  {52'h0, bus1.mem_addr}, {52'h0, v.addr});
        chk("ready_busy", {62'h0, bus1.req_ready}, 64'h0);
        if (v.we) begin
            chk("mem_wdata", {32'h0, bus1.mem_wdata}, {32'h0, v.wdata});
            chk("mem_mask",  {32'h0, bus1.mem_mask}, {32'h0, v.mask});
        end
        @(posedge clk); #1;
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[7];

    initial begin
        tbl[0] = '{port: 1'b0, we: 1'b1, addr: 12'h010, wdata: 32'hDEADBEEF, mask: 32'hFFFFFFFF, exp: 32'h0};
        tbl[1] = '{port: 1'b1, we: 1'b0, addr: 12'h010, wdata: 32'h0, mask: 32'h0, exp: 32'hDEADBEEF};
        tbl[2] = '{port: 1'b1, we: 1'b1, addr: 12'h020, wdata: 32'h12345678, mask: 32'h0000FFFF, exp: 32'h0};
        tbl[3] = '{port: 1'b0, we: 1'b0, addr: 12'h020, wdata: 32'h0, mask: 32'h0, exp: 32'h00005678};
        tbl[4] = '{port: 1'b0, we: 1'b1, addr: 12'h020, wdata: 32'hAABBCCDD, mask: 32'hFF000000, exp: 32'h0};
        tbl[5] = '{port: 1'b1, we: 1'b0, addr: 12'h020, wdata: 32'h0, mask: 32'h0, exp: 32'hAA005678};
        tbl[6] = '{port: 1'b0, we: 1'b0, addr: 12'h3FC, wdata: 32'h0, mask: 32'h0, exp: 32'h5A5A5A5A};

        idle_inputs();
        bus3.req_valid = 2'b00;
        bus3.req_we    = 2'b00;
        bus3.req_addr  = '0;
        bus3.req_wdata = '0;
        bus3.req_mask  = '0;

        // Reset: two cycles, everything idle and zero.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",     {62'h0, bus1.req_ready}, 64'h0);
        chk("rst_rsp_valid", {62'h0, bus1.rsp_valid}, 64'h0);
        chk("rst_rsp_data",  {32'h0, bus1.rsp_data}, 64'h0);
        chk("rst_mem_en",    {63'h0, bus1.mem_en}, 64'h0);
        chk("rst_mem_we",    {63'h0, bus1.mem_we}, 64'h0);
        chk("rst_mem_addr",  {52'h0, bus1.mem_addr}, 64'h0);
        chk("rst_mem_wdata", {32'h0, bus1.mem_wdata}, 64'h0);
        chk("rst_mem_mask",  {32'h0, bus1.mem_mask}, 64'h0);
        chk("rst3_mem_en",   {63'h0, bus3.mem_en}, 64'h0);
        chk("rst3_rsp_valid", {62'h0, bus3.rsp_valid}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_mem_en", {63'h0, bus1.mem_en}, 64'h0);
        @(posedge clk); #1;

        // Contention right after reset: both ports read continuously.
        begin
            int last = 0;
            bus1.req_valid = 2'b11;
            bus1.req_we    = 2'b00;
            bus1.req_addr  = {12'h044, 12'h040};
            for (int g = 0; g < 4; g++) begin
                int waited = 0;
                bit ep;
`ifdef MEM_ARB_FIXED_PRIO_EN
                ep = 1'b0;
`else
                ep = g[0];
`endif
                forever begin
                    @(negedge clk);
                    if (bus1.req_ready != 2'b00 || waited >= 20) break;
                    waited++;
                    @(posedge clk); #1;
                end
                chk("rr_grant", {62'h0, bus1.req_ready}, {62'h0, oh(ep)});
                if (g > 0) chk("rr_gap", 64'(cyc - last), 64'd4);
                last = cyc;
                sb.push_back('{port: ep, data: ep ? 32'hB1B1B1B1 : 32'hA0A0A0A0, cyc: cyc + 3});
                n_exp_men++;
                @(posedge clk); #1;
            end
            idle_inputs();
            wait_drain();
        end

        // Table of single transactions.
        for (int i = 0; i < 7; i++) do_txn(tbl[i], 1'b0);

        // Read abandoned by reset while in WAIT; next request accepted immediately.
        bus1.req_valid = 2'b10;
        bus1.req_we    = 2'b00;
        bus1.req_addr  = {12'h044, 12'h000};
        @(negedge clk);
        chk("abort_ready", {62'h0, bus1.req_ready}, 64'h2);
        n_exp_men++;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_wait_mem_en", {63'h0, bus1.mem_en}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_txn('{port: 1'b0, we: 1'b0, addr: 12'h040, wdata: 32'h0, mask: 32'h0,
                 exp: 32'hA0A0A0A0}, 1'b1);

        // LAT=3 instance: rsp at T+5, no acceptance while busy.
        bus3.req_valid = 2'b01;
        bus3.req_we    = 2'b00;
        bus3.req_addr  = {12'h000, 12'h040};
        @(negedge clk);
        chk("lat3_ready", {62'h0, bus3.req_ready}, 64'h1);
        @(posedge clk); #1;
        bus3.req_valid = 2'b10;
        bus3.req_addr  = {12'h044, 12'h000};
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk("lat3_busy_ready", {62'h0, bus3.req_ready}, 64'h0);
            chk("lat3_rsp_valid", {62'h0, bus3.rsp_valid}, (k == 5) ? 64'h1 : 64'h0);
            chk("lat3_mem_en", {63'h0, bus3.mem_en}, (k == 1) ? 64'h1 : 64'h0);
        end
        chk("lat3_rsp_data", {32'h0, bus3.rsp_data}, 64'hC3C3C3C3);
        @(posedge clk); #1;
        bus3.req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;

        chk("sb_empty", 64'(sb.size()), 64'h0);
        chk("mem_en_count", 64'(n_men), 64'(n_exp_men));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
